// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
// Module  : mem_controller
// Brief   : Round-robin arbiter sharing one memory read/write port among LSUs.
// Rev     : 1.0 - initial release
// ============================================================================
module mem_controller #(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_addr,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_addr,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_addr,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data,
   output logic                               mem_write_valid,
   output logic [ADDR_BITS-1:0]               mem_write_addr,
   output logic [DATA_BITS-1:0]               mem_write_data,
   input  logic                               mem_write_ready
);
   localparam int                    c_PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam logic [c_PTR_BITS:0]   c_NUM      = (c_PTR_BITS + 1)'(NUM_CONSUMERS);
   localparam logic [c_PTR_BITS-1:0] c_LAST     = c_PTR_BITS'(NUM_CONSUMERS - 1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      READ_WAIT   = 3'd1,
      WRITE_WAIT  = 3'd2,
      READ_RELAY  = 3'd3,
      WRITE_RELAY = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [c_PTR_BITS-1:0] r_rr_ptr;
   logic [c_PTR_BITS-1:0] r_grant;
   logic [c_PTR_BITS-1:0] w_gidx;
   logic [c_PTR_BITS-1:0] w_idx;
   logic [c_PTR_BITS-1:0] w_next_ptr;
   logic [c_PTR_BITS:0]   w_sum;
   logic                  w_found;
   logic                  w_gread;
   logic                  w_g_rvalid;
   logic                  w_g_wvalid;

   // Descending scan so the lowest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      w_found = 1'b0;
      w_gread = 1'b0;
      w_gidx  = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_rr_ptr} + (c_PTR_BITS + 1)'(k);
         if (w_sum >= c_NUM) begin
            w_sum = w_sum - c_NUM;
         end
         w_idx = w_sum[c_PTR_BITS-1:0];
         if (consumer_read_valid[w_idx] || consumer_write_valid[w_idx]) begin
            w_found = 1'b1;
            w_gidx  = w_idx;
            w_gread = consumer_read_valid[w_idx];
         end
      end
   end

   assign w_next_ptr = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;
   assign w_g_rvalid = consumer_read_valid[r_grant];
   assign w_g_wvalid = consumer_write_valid[r_grant];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_next = w_gread ? READ_WAIT : WRITE_WAIT;
            end
         end
         READ_WAIT:   if (mem_read_ready)  w_state_next = READ_RELAY;
         WRITE_WAIT:  if (mem_write_ready) w_state_next = WRITE_RELAY;
         READ_RELAY:  if (!w_g_rvalid)     w_state_next = IDLE;
         WRITE_RELAY: if (!w_g_wvalid)     w_state_next = IDLE;
         default:     w_state_next = IDLE;
      endcase
   end

   // Memory-side and consumer-side outputs are registered; they change only with the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rr_ptr             <= '0;
         r_grant              <= '0;
         mem_read_valid       <= 1'b0;
         mem_read_addr        <= '0;
         mem_write_valid      <= 1'b0;
         mem_write_addr       <= '0;
         mem_write_data       <= '0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         consumer_read_data   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant  <= w_gidx;
                  r_rr_ptr <= w_next_ptr;
                  if (w_gread) begin
                     mem_read_valid <= 1'b1;
                     mem_read_addr  <= consumer_read_addr[w_gidx*ADDR_BITS +: ADDR_BITS];
                  end else begin
                     mem_write_valid <= 1'b1;
                     mem_write_addr  <= consumer_write_addr[w_gidx*ADDR_BITS +: ADDR_BITS];
                     mem_write_data  <= consumer_write_data[w_gidx*DATA_BITS +: DATA_BITS];
                  end
               end
            end
            READ_WAIT: begin
               if (mem_read_ready) begin
                  consumer_read_data[r_grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
                  consumer_read_ready[r_grant] <= 1'b1;
                  mem_read_valid               <= 1'b0;
               end
            end
            WRITE_WAIT: begin
               if (mem_write_ready) begin
                  consumer_write_ready[r_grant] <= 1'b1;
                  mem_write_valid               <= 1'b0;
               end
            end
            READ_RELAY: begin
               if (!w_g_rvalid) begin
                  consumer_read_ready <= '0;
               end
            end
            WRITE_RELAY: begin
               if (!w_g_wvalid) begin
                  consumer_write_ready <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_controller.md
MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of LSU requesters sharing one memory port.
REQ-002 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have ports consumer_read_valid  input  NUM_CONSUMERS  and consumer_read_addr  input  NUM_CONSUMERS*ADDR_BITS  per-LSU read request; slice i = bits [i*ADDR_BITS +: ADDR_BITS].
REQ-007 SHALL have ports consumer_read_ready  output  NUM_CONSUMERS  and consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  per-LSU read response.
REQ-008 SHALL have ports consumer_write_valid  input  NUM_CONSUMERS, consumer_write_addr  input  NUM_CONSUMERS*ADDR_BITS, consumer_write_data  input  NUM_CONSUMERS*DATA_BITS, consumer_write_ready  output  NUM_CONSUMERS.
REQ-009 SHALL have ports mem_read_valid  output  1, mem_read_addr  output  ADDR_BITS, mem_read_ready  input  1, mem_read_data  input  DATA_BITS.
REQ-010 SHALL have ports mem_write_valid  output  1, mem_write_addr  output  ADDR_BITS, mem_write_data  output  DATA_BITS, mem_write_ready  input  1.

Function
REQ-011 SHALL implement FSM states IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY; one transaction outstanding at a time.
REQ-012 SHALL, in IDLE, scan consumers starting at round-robin pointer rr_ptr, index wrapping NUM_CONSUMERS-1 -> 0, and grant the first with read_valid or write_valid high.
REQ-013 SHALL, if the granted consumer has both read_valid and write_valid high, serve the read first.
REQ-014 SHALL, on a read grant to consumer g: register g, set mem_read_valid=1 and mem_read_addr=slice g, go READ_WAIT (mem_read_valid visible 1 cycle after request sampled).
REQ-015 SHALL, on a write grant: set mem_write_valid=1, mem_write_addr/mem_write_data=slice g, go WRITE_WAIT.
REQ-016 SHALL set rr_ptr to (g+1) mod NUM_CONSUMERS on every grant; rr_ptr unchanged when no request.
REQ-017 SHALL hold mem_*_valid, addr and data stable in *_WAIT until the matching mem_*_ready is sampled high.
REQ-018 SHALL, in READ_WAIT on mem_read_ready=1: capture mem_read_data into consumer_read_data slice g, set consumer_read_ready[g]=1, mem_read_valid=0, go READ_RELAY.
REQ-019 SHALL, in WRITE_WAIT on mem_write_ready=1: set consumer_write_ready[g]=1, mem_write_valid=0, go WRITE_RELAY.
REQ-020 SHALL, in *_RELAY, hold consumer ready[g] high until consumer valid[g] sampled low, then clear ready[g] and return IDLE the next edge.
REQ-021 SHALL complete a memory transaction already issued even if consumer valid[g] drops during *_WAIT; ready[g] then pulses exactly one cycle in *_RELAY.
REQ-022 SHALL keep consumer_read_data slice g valid at least while consumer_read_ready[g]=1; other slices retain last value.
REQ-023 SHALL never assert mem_read_valid and mem_write_valid together, nor more than one consumer ready bit at once.
REQ-024 SHALL not issue a new grant in the cycle IDLE is re-entered; earliest re-grant is the following edge.
REQ-025 SHALL ignore mem_*_ready when not in the matching *_WAIT state.

Reset
REQ-026 SHALL, while reset=0, asynchronously force state=IDLE, rr_ptr=0, all mem_*_valid=0, mem addr/data=0, all consumer ready bits=0, consumer_read_data=0.
REQ-027 SHALL, on reset mid-transaction, abandon it without completion; after release the first grant evaluates from consumer 0.

Verification
REQ-028 Single read: consumer 2 read addr 0x3C, memory ready 2 cycles later with 0xA5 -> mem_read_addr=0x3C, consumer_read_data[2]=0xA5, consumer_read_ready[2] high until valid drops, then IDLE.
REQ-029 Round-robin: consumers 0,1,3 request reads simultaneously, rr_ptr=0 -> grant order 0,1,3; rr_ptr=0 after the third grant.
REQ-030 Write: consumer 1 writes 0x77 to 0x10 -> mem_write_valid with addr 0x10 data 0x77 held until mem_write_ready; consumer_write_ready[1] asserted; mem_read_valid stays 0.
REQ-031 Read+write same consumer: consumer 0 both valid -> read served first, write granted only after rr_ptr wraps back to 0 with no other requesters.
REQ-032 Abandon: consumer 3 drops read_valid during READ_WAIT -> memory transaction completes, consumer_read_ready[3] pulses one cycle, then IDLE.
REQ-033 Reset mid-op: reset=0 during WRITE_WAIT -> mem_write_valid=0 immediately (asynchronous), all ready bits 0; after release consumer 0 granted first.
